div_unit: RTL and testbench

- Multi-cycle 32-bit divider serving the execute stage's DIV/DIVU instructions.
- Accepts operands and a start request from the execute stage.
- Runs a radix-2 restoring division over 32 iterations, then returns {remainder, quotient} with a ready flag; the execute stage holds the pipeline stalled until the flag is seen.
- Sits beside the execute stage, clocked with the pipeline; its result is consumed as the HI/LO write data.

---
 rtl/div_unit_pkg.sv | 21 ++
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 155 +++++++++++++++
 tb/tb_div_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared defines for the execute-stage divider.
//   - div_state_e : FSM state encodings
//   - DivStart/DivStop, DivResultReady/DivResultNotReady : handshake levels
//   - DoubleRegBus : width of the {HI, LO} result bus
package div_unit_pkg;

  localparam int DoubleRegBus = 64;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring iteration.
// Work register layout: [2W:W+1] partial remainder, [W:1] dividend bits
// still to be consumed, quotient bits shifted in at [0].
//   work_i    : work register before the iteration
//   divisor_i : divisor magnitude
//   work_o    : work register after trial subtract and shift
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0] work_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [2*DATA_W:0] work_o
);

  // The trial value {remainder, next dividend bit} is DATA_W+1 bits wide, so
  // compare at full width; when it is >= divisor the difference always fits
  // in DATA_W bits.
  logic              ge;
  logic [DATA_W-1:0] diff;

  always_comb begin
    ge   = work_i[2*DATA_W:DATA_W] >= {1'b0, divisor_i};
    diff = work_i[2*DATA_W-1:DATA_W] - divisor_i;
    if (ge) work_o = {diff, work_i[DATA_W-1:0], 1'b1};
    else    work_o = {work_i[2*DATA_W-1:0], 1'b0};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle DIV/DIVU unit beside the execute stage.
// Radix-2 restoring division over DATA_W iterations, then sign fixup.
//   clk, rst       : clock, synchronous active-high reset
//   signed_div_i   : 1 = DIV (signed), 0 = DIVU
//   opdata1_i/2_i  : dividend / divisor, latched on the accepting edge
//   start_i        : request, held until ready_o is seen; dropping it aborts
//   annul_i        : flush the in-flight division
//   result_o       : {remainder, quotient}
//   ready_o        : result valid, held while start_i stays high
// Optional: define DIV_EARLY_OUT_EN to finish in one iteration slot when
// |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DoubleRegBus / 2,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W:0]   work_q, work_d, work_step;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                sgn_q, sgn_d, neg1_q, neg1_d, neg2_q, neg2_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic              neg1, neg2;
  logic [DATA_W-1:0] mag1, mag2, quo_fix, rem_fix;

  div_step #(.DATA_W(DATA_W)) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_step)
  );

  always_comb begin
    neg1    = signed_div_i & opdata1_i[DATA_W-1];
    neg2    = signed_div_i & opdata2_i[DATA_W-1];
    mag1    = neg1 ? -opdata1_i : opdata1_i;
    mag2    = neg2 ? -opdata2_i : opdata2_i;
    quo_fix = (sgn_q & (neg1_q ^ neg2_q)) ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
    rem_fix = (sgn_q & neg1_q) ? -work_q[2*DATA_W:DATA_W+1] : work_q[2*DATA_W:DATA_W+1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    sgn_d     = sgn_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    result_d  = result_q;
    ready_d   = ready_q;
    unique case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (start_i == DivStart && !annul_i) begin
          sgn_d     = signed_div_i;
          neg1_d    = neg1;
          neg2_d    = neg2;
          divisor_d = mag2;
          cnt_d     = '0;
          if (mag2 == '0) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            work_d  = {{DATA_W{1'b0}}, mag1, 1'b0};
`ifdef DIV_EARLY_OUT_EN
            // Quotient is 0 and remainder is the dividend: preload the
            // finished layout and jump straight to the fixup slot.
            if (mag1 < mag2) begin
              cnt_d  = LastCnt;
              work_d = {mag1, {DATA_W{1'b0}}, 1'b0};
            end
`endif
          end
        end
      end
      DivByZero: begin
        if (annul_i || start_i == DivStop) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i || start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt_q != LastCnt) begin
          work_d = work_step;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          state_d  = DivEnd;
          cnt_d    = '0;
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      sgn_q     <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      sgn_q     <= sgn_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb2, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a; sb2 = b;
    q = sa / sb2;
    r = sa % sb2;
    return {32'(r), 32'(q)};
  endfunction

  function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    if (b == 32'd0) return 1;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return (ma == 32'hFFFF_FFFF && mb == 32'hFFFF_FFFF) ? 33 : 33;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expv);
    exp_t e;
    int   n;
    @(negedge clk);
    signed_div = s; op1 = a; op2 = b; start = 1'b1;
    e.res = expv;
    e.lat = exp_lat(s, a, b);
    sb.push_back(e);
    @(posedge clk); #1;  // E0 taken; scramble operands to prove they are latched
    op1 = ~a; op2 = ~b; signed_div = ~s;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    check({tag, ":latency"}, 64'(n), 64'(e.lat));
    check({tag, ":result"}, result, e.res);
    repeat (2) @(posedge clk);
    #1;
    check({tag, ":hold_rdy"}, 64'(ready), 64'd1);
    check({tag, ":hold_res"}, result, e.res);
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    check({tag, ":drop_rdy"}, 64'(ready), 64'd0);
    check({tag, ":drop_res"}, result, 64'd0);
  endtask

  initial begin
    logic        seen;
    logic [31:0] ra, rb;
    logic        rs;
    rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset:rdy", 64'(ready), 64'd0);
    check("reset:res", result, 64'd0);
    @(negedge clk) rst = 1'b0;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_div("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 64'h00000001_7FFFFFFC);
    run_div("byzero", 1'b0, 32'h1234_5678, 32'd0, 64'd0);
    run_div("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
    run_div("u5_9", 1'b0, 32'd5, 32'd9, 64'h00000005_00000000);
    run_div("s_m5_9", 1'b1, 32'hFFFF_FFFB, 32'd9, 64'hFFFFFFFB_00000000);
    run_div("u_big", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 64'h00000001_00000001);

    // annul at E10
    @(negedge clk) signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(posedge clk);          // E0
    repeat (9) @(posedge clk);  // E9
    @(negedge clk) annul = 1'b1;
    @(posedge clk); #1;      // E10
    check("annul:rdy", 64'(ready), 64'd0);
    @(negedge clk) annul = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (ready) seen = 1'b1; end
    check("annul:never_rdy", 64'(seen), 64'd0);
    run_div("after_annul", 1'b1, 32'd1000, 32'hFFFF_FFFD, model(1'b1, 32'd1000, 32'hFFFF_FFFD));

    // start dropped mid-ON aborts
    @(negedge clk) signed_div = 1'b0; op1 = 32'd77; op2 = 32'd5; start = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk) start = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready) seen = 1'b1; end
    check("abort:never_rdy", 64'(seen), 64'd0);

    // synchronous reset mid-ON
    @(negedge clk) signed_div = 1'b0; op1 = 32'd99; op2 = 32'd4; start = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("rst_mid:rdy", 64'(ready), 64'd0);
    check("rst_mid:res", result, 64'd0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready) seen = 1'b1; end
    check("rst_mid:never_rdy", 64'(seen), 64'd0);
    run_div("after_rst", 1'b0, 32'd99, 32'd4, 64'h00000003_00000018);

    // random operands against the behavioural model
    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i == 5) ra = 32'($urandom_range(0, 3));
      run_div($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
